// File: rtl/axi_pkg.sv
// Shared AXI encodings and read/write generator FSM state constants.
// Used by the delay gate, the read burst generator and the write-side generator.
package axi_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] burst_t;
  typedef logic [1:0] resp_t;

  localparam burst_t BURST_FIXED = 2'd0;
  localparam burst_t BURST_INCR  = 2'd1;
  localparam burst_t BURST_WRAP  = 2'd2;
  localparam burst_t BURST_RSVD  = 2'd3;

  localparam resp_t RESP_OKAY   = 2'd0;
  localparam resp_t RESP_SLVERR = 2'd2;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t DRAIN = 2'd2;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_rd_burst_gen_if.sv
// Bus bundle for axi_rd_burst_gen: gated AR channel, RAM read port and R channel.
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable and valid high until that edge.
interface axi_rd_burst_gen_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  localparam int STRB_LOG = $clog2(DATA_WIDTH / 8);

  logic [ID_WIDTH-1:0]            s_arid;
  logic [ADDR_WIDTH-1:0]          s_araddr;
  logic [7:0]                     s_arlen;
  logic [2:0]                     s_arsize;
  logic [1:0]                     s_arburst;
  logic                           s_arvalid;
  logic                           s_arready;

  logic                           mem_rd_en;
  logic [ADDR_WIDTH-STRB_LOG-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]          mem_rd_data;

  logic [ID_WIDTH-1:0]            m_rid;
  logic [DATA_WIDTH-1:0]          m_rdata;
  logic [1:0]                     m_rresp;
  logic                           m_rlast;
  logic                           m_rvalid;
  logic                           m_rready;

  modport slave (
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    output s_arready,
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  m_rready
  );

  modport master (
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    input  s_arready,
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output m_rready
  );

endinterface

// File: rtl/axi_rd_skid.sv
// Two-entry R output FIFO; occupancy feeds the read-issue credit check.
// The head entry is held stable until it is popped.
module axi_rd_skid #(
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   occ
);

  logic [W-1:0] slot_q [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
    end else begin
      if (push) begin
        slot_q[wr_ptr] <= push_data;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = slot_q[rd_ptr];
  assign valid = (count != 2'd0);
  assign occ   = count;

endmodule

// File: rtl/axi_rd_burst_gen.sv
// AXI4 read burst generator: expands a gated AR burst into 1-cycle-latency RAM
// reads and returns R beats. Define AXI_RD_BURST_WRAP_EN to support WRAP bursts.
module axi_rd_burst_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  axi_rd_burst_gen_if.slave   bus,
  output state_t              dbg_state
);

  localparam int         STRB_LOG = $clog2(DATA_WIDTH / 8);
  localparam logic [2:0] MAX_SIZE = 3'(STRB_LOG);
  localparam int         PW       = DATA_WIDTH + 3;

  state_t                state;
  logic                  ar_ready_r;
  logic [ID_WIDTH-1:0]   id_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] wmask_r;
  logic [7:0]            len_r;
  logic [7:0]            beat_r;
  logic [2:0]            size_r;
  burst_t                mode_r;
  logic                  err_r;

  logic                  pend_r;
  logic                  pend_last_r;
  logic                  pend_err_r;

  logic [1:0]            occ;
  logic                  buf_valid;
  logic [PW-1:0]         head;
  logic                  pop;
  logic                  issue;
  logic                  ar_fire;

  logic [2:0]            ar_size_eff;
  logic                  ar_err;
  burst_t                ar_mode;
  logic [ADDR_WIDTH-1:0] ar_wmask;
`ifdef AXI_RD_BURST_WRAP_EN
  logic [ADDR_WIDTH-1:0] ar_step;
`endif

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] next_addr;

  // Decode the AR request; an oversize beat is still read at the bus width.
  always_comb begin
    ar_err      = (bus.s_arsize > MAX_SIZE);
    ar_size_eff = ar_err ? MAX_SIZE : bus.s_arsize;
    ar_mode     = (bus.s_arburst == BURST_FIXED) ? BURST_FIXED : BURST_INCR;
    ar_wmask    = ((ADDR_WIDTH'({1'b0, bus.s_arlen}) + ADDR_WIDTH'(1)) << ar_size_eff)
                  - ADDR_WIDTH'(1);
`ifdef AXI_RD_BURST_WRAP_EN
    ar_step     = ADDR_WIDTH'(1) << ar_size_eff;
    if (bus.s_arburst == BURST_WRAP) begin
      if (wrap_len_legal(bus.s_arlen) &&
          ((bus.s_araddr & (ar_step - ADDR_WIDTH'(1))) == '0)) begin
        ar_mode = BURST_WRAP;
      end else begin
        ar_err = 1'b1;
      end
    end else if (bus.s_arburst == BURST_RSVD) begin
      ar_err = 1'b1;
    end
`else
    if (bus.s_arburst == BURST_RSVD) begin
      ar_err = 1'b1;
    end
`endif
  end

  // Only the first beat of an unaligned INCR burst is unaligned.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size_r;
    incr_addr = (addr_r & ~(step - ADDR_WIDTH'(1))) + step;
    case (mode_r)
      BURST_FIXED: next_addr = addr_r;
      BURST_WRAP:  next_addr = (addr_r & ~wmask_r) | (incr_addr & wmask_r);
      default:     next_addr = incr_addr;
    endcase
  end

  assign ar_fire = (state == IDLE) && ar_ready_r && bus.s_arvalid;
  assign pop     = buf_valid && bus.m_rready;
  // Credit: buffered + in-flight beats, less the one leaving now, must stay below 2.
  assign issue   = (state == ISSUE) &&
                   (({1'b0, occ} + {2'b00, pend_r} - {2'b00, pop}) < 3'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      ar_ready_r  <= 1'b0;
      id_r        <= '0;
      addr_r      <= '0;
      wmask_r     <= '0;
      len_r       <= '0;
      beat_r      <= '0;
      size_r      <= '0;
      mode_r      <= BURST_FIXED;
      err_r       <= 1'b0;
      pend_r      <= 1'b0;
      pend_last_r <= 1'b0;
      pend_err_r  <= 1'b0;
    end else begin
      pend_r      <= issue;
      pend_last_r <= issue && (beat_r == len_r);
      pend_err_r  <= err_r;
      case (state)
        IDLE: begin
          if (ar_fire) begin
            id_r       <= bus.s_arid;
            addr_r     <= bus.s_araddr;
            len_r      <= bus.s_arlen;
            size_r     <= ar_size_eff;
            mode_r     <= ar_mode;
            wmask_r    <= ar_wmask;
            err_r      <= ar_err;
            beat_r     <= '0;
            ar_ready_r <= 1'b0;
            state      <= ISSUE;
          end else begin
            ar_ready_r <= 1'b1;
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_r <= next_addr;
            if (beat_r == len_r) begin
              state <= DRAIN;
            end else begin
              beat_r <= beat_r + 8'd1;
            end
          end
        end
        DRAIN: begin
          if ((occ == 2'd0) && !pend_r) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axi_rd_skid #(.W(PW)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_r),
    .push_data ({bus.mem_rd_data, pend_last_r, (pend_err_r ? RESP_SLVERR : RESP_OKAY)}),
    .pop       (pop),
    .head      (head),
    .valid     (buf_valid),
    .occ       (occ)
  );

  assign bus.s_arready = ar_ready_r;
  assign bus.mem_rd_en = issue;
  assign bus.mem_addr  = addr_r[ADDR_WIDTH-1:STRB_LOG];

  assign bus.m_rvalid  = buf_valid;
  assign bus.m_rdata   = buf_valid ? head[PW-1:3] : '0;
  assign bus.m_rlast   = buf_valid && head[2];
  assign bus.m_rresp   = buf_valid ? head[1:0] : RESP_OKAY;
  assign bus.m_rid     = buf_valid ? id_r : '0;

  assign dbg_state     = state;

endmodule
